minmax_seq_ctrl: RTL and testbench

- Sequencer for the signed min/max tracking datapath. On `start` it clears the datapath, then streams exactly `count` samples from an upstream valid/ready source into it.
- Drives the datapath's `clear`/`load` strobes and data input, and pulses `done` when the datapath's min/max outputs hold the final result.
- Sits between a sample producer (memory reader or input port) and the datapath. It is the only driver of the datapath controls.

---
 rtl/minmax_seq_ctrl_if.sv | 13 +
 rtl/minmax_seq_ctrl.sv | 107 ++++++++++
 tb/tb_minmax_seq_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/minmax_seq_ctrl_if.sv
// Upstream sample stream into the min/max sequencer: a plain valid/ready
// handshake. The producer side uses the master modport and the sequencer
// uses the slave modport.
interface minmax_seq_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/minmax_seq_ctrl.sv
// Sequencer for the signed min/max tracking datapath. A run clears the
// datapath for one cycle, streams exactly `count` samples into it from the
// upstream valid/ready source, then pulses `done` for one cycle. At that
// point the datapath min/max outputs hold the final result.
module minmax_seq_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  count,
  minmax_seq_ctrl_if.slave  up,
  output logic              dp_clear,
  output logic              dp_load,
  output logic [DATA_W-1:0] dp_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  remaining
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] remaining_next;
  logic             accept;
  logic             last_beat;

  // A sample is taken only in RUN, only when nothing is aborting the run.
  assign accept    = (state == S_RUN) && !abort && up.in_valid;
  assign last_beat = (remaining == CNT_W'(1));

  // State and remaining-count registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      remaining <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of process order.
      state     <= state_next;
      remaining <= remaining_next;
    end
  end

  // Next-state and next-count decode.
  always_comb begin
    // NOTE: defaults first so every path assigns both signals; a missing
    // branch would otherwise infer a latch.
    state_next     = state;
    remaining_next = remaining;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_next     = S_CLEAR;
          remaining_next = count;
        end
      end
      S_CLEAR: begin
        if (abort) begin
          state_next     = S_IDLE;
          remaining_next = '0;
        end else if (remaining == '0) begin
          state_next = S_DONE;
        end else begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_next     = S_IDLE;
          remaining_next = '0;
        end else if (accept && remaining != '0) begin
          // Guarded decrement: the count never wraps below zero.
          remaining_next = remaining - CNT_W'(1);
          if (last_beat) state_next = S_DONE;
        end
      end
      S_DONE: begin
        // start and abort are both ignored here.
        state_next = S_IDLE;
      end
      default: begin
        state_next     = S_IDLE;
        remaining_next = '0;
      end
    endcase
  end

  // Output decode: Moore strobes from state; ready/load also see abort and valid.
  always_comb begin
    dp_clear    = (state == S_CLEAR);
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
    up.in_ready = (state == S_RUN) && !abort;
    dp_load     = accept;
    dp_data     = up.in_data;
  end

endmodule

// File: tb/tb_minmax_seq_ctrl.sv
// Self-checking bench for minmax_seq_ctrl. The driver issues runs and
// pushes the expected end-of-run result into a scoreboard queue. A
// negedge monitor pops the queue on every done pulse and compares against
// a behavioural datapath fed by the DUT's clear/load strobes.
module tb_minmax_seq_ctrl;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam logic signed [31:0] S_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] S_MIN = 32'sh8000_0000;

  typedef logic signed [31:0] sample_t;
  typedef struct {
    sample_t mn;
    sample_t mx;
    int      loads;
    int      latency;
  } exp_t;

  logic              clock   = 1'b0;
  logic              reset_n = 1'b0;
  logic              start   = 1'b0;
  logic              abort   = 1'b0;
  logic [CNT_W-1:0]  count   = '0;
  logic              dp_clear;
  logic              dp_load;
  logic [DATA_W-1:0] dp_data;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  remaining;

  minmax_seq_ctrl_if #(.DATA_W(DATA_W)) up ();

  minmax_seq_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .count     (count),
    .up        (up),
    .dp_clear  (dp_clear),
    .dp_load   (dp_load),
    .dp_data   (dp_data),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  always #5 clock = ~clock;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result of a run: min/max over the samples, starting from the
  // datapath's clear sentinels.
  function automatic exp_t ref_run(input sample_t d[$], input int lat);
    exp_t e;
    e.mn = S_MAX;
    e.mx = S_MIN;
    foreach (d[i]) begin
      if (d[i] < e.mn) e.mn = d[i];
      if (d[i] > e.mx) e.mx = d[i];
    end
    e.loads   = d.size();
    e.latency = lat;
    return e;
  endfunction

  // Behavioural datapath plus monitor.
  sample_t m_min, m_max;
  logic    cap_clr, cap_ld;
  sample_t cap_d;
  int      cyc = 0;
  int      start_cyc = 0;
  int      run_loads = 0;

  always @(posedge clock) begin
    if (reset_n) begin
      if (cap_clr) begin
        m_min = S_MAX;
        m_max = S_MIN;
      end else if (cap_ld) begin
        if (cap_d < m_min) m_min = cap_d;
        if (cap_d > m_max) m_max = cap_d;
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    cyc++;
    cap_clr = dp_clear;
    cap_ld  = dp_load;
    cap_d   = $signed(dp_data);
    if (reset_n) begin
      check("clear_load_exclusive", dp_clear & dp_load, 0);
      check("load_only_when_busy", dp_load & ~busy, 0);
      if (!busy && start) start_cyc = cyc;
      if (dp_clear) run_loads = 0;
      if (dp_load) run_loads++;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          e = sb.pop_front();
          check("result_min", m_min, e.mn);
          check("result_max", m_max, e.mx);
          check("load_count", run_loads, e.loads);
          check("run_latency", cyc - start_cyc, e.latency);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Driver helpers: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_run(input int n);
    count = CNT_W'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_ready();
    int k = 0;
    @(negedge clock);
    while (!up.in_ready && k < 20) begin
      @(negedge clock);
      k++;
    end
    if (!up.in_ready) check("ready_timeout", up.in_ready, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clock);
    while (busy && k < 50) begin
      @(negedge clock);
      k++;
    end
    if (busy) check("idle_timeout", busy, 0);
    tick();
  endtask

  task automatic stream(input sample_t d[$], input int gaps[$], input int n);
    for (int i = 0; i < d.size(); i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        up.in_valid = 1'b0;
        @(negedge clock);
        check("remaining_stall", remaining, CNT_W'(n - i));
        tick();
      end
      up.in_valid = 1'b1;
      up.in_data  = d[i];
      wait_ready();
      check("remaining_beat", remaining, CNT_W'(n - i));
      tick();
    end
    up.in_valid = 1'b0;
  endtask

  task automatic run_normal(input sample_t d[$], input int gaps[$]);
    int lat = 2 + d.size();
    foreach (gaps[i]) lat += gaps[i];
    sb.push_back(ref_run(d, lat));
    start_run(d.size());
    @(negedge clock);
    check("clear_strobe", dp_clear, 1);
    check("remaining_latched", remaining, CNT_W'(d.size()));
    tick();
    stream(d, gaps, d.size());
    @(negedge clock);
    check("remaining_at_done", remaining, 0);
    wait_idle();
  endtask

  initial begin
    sample_t d[$];
    sample_t held[$];
    int      gaps[$];
    int      idx, dones, after;
    int      n;

    up.in_valid = 1'b0;
    up.in_data  = 32'h1234_5678;

    // Reset state.
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_clear", dp_clear, 0);
    check("rst_load", dp_load, 0);
    check("rst_ready", up.in_ready, 0);
    check("rst_remaining", remaining, 0);
    check("rst_dp_data", dp_data, up.in_data);
    #9 reset_n = 1'b1;
    tick();

    // count=4, continuous valid.
    d = '{32'sd5, -32'sd3, 32'sd12, 32'sd7};
    gaps = '{0, 0, 0, 0};
    run_normal(d, gaps);

    // count=3 with valid on RUN cycles 1, 4, 5.
    d = '{-32'sd100, 32'sd0, 32'sd100};
    gaps = '{0, 2, 0};
    run_normal(d, gaps);

    // count=0: CLEAR straight to DONE, sentinels remain.
    d = {};
    gaps = {};
    run_normal(d, gaps);

    // count=5, abort on the 3rd RUN cycle with valid high.
    start_run(5);
    tick();
    up.in_valid = 1'b1;
    up.in_data  = 32'd1;
    tick();
    up.in_data  = 32'd2;
    tick();
    abort = 1'b1;
    up.in_data = 32'd3;
    @(negedge clock);
    check("abort_load", dp_load, 0);
    check("abort_ready", up.in_ready, 0);
    tick();
    abort = 1'b0;
    up.in_valid = 1'b0;
    @(negedge clock);
    check("abort_busy", busy, 0);
    check("abort_remaining", remaining, 0);
    tick();
    tick();
    d = '{32'sd9};
    gaps = '{0};
    run_normal(d, gaps);

    // Reset mid-RUN: count=8, 3 beats accepted.
    start_run(8);
    tick();
    up.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      up.in_data = 32'(i + 40);
      tick();
    end
    up.in_data = 32'hCAFE_0001;
    #2 reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_load", dp_load, 0);
    check("midrst_ready", up.in_ready, 0);
    check("midrst_clear", dp_clear, 0);
    check("midrst_done", done, 0);
    check("midrst_remaining", remaining, 0);
    check("midrst_dp_data", dp_data, 32'hCAFE_0001);
    up.in_valid = 1'b0;
    #17 reset_n = 1'b1;
    tick();
    @(negedge clock);
    check("post_rst_busy", busy, 0);
    tick();

    // Largest count latches without wrapping; abort after one beat.
    start_run(65535);
    @(negedge clock);
    check("max_count_latched", remaining, 16'hFFFF);
    tick();
    up.in_valid = 1'b1;
    up.in_data  = 32'd77;
    @(negedge clock);
    check("max_count_accept", dp_load, 1);
    tick();
    up.in_valid = 1'b0;
    abort = 1'b1;
    @(negedge clock);
    check("max_count_dec", remaining, 16'hFFFE);
    tick();
    abort = 1'b0;
    @(negedge clock);
    check("max_count_abort", remaining, 0);
    tick();

    // start held high: two back-to-back count=2 runs.
    held = '{S_MIN, S_MAX, S_MIN, S_MAX};
    d = '{S_MIN, S_MAX};
    sb.push_back(ref_run(d, 4));
    sb.push_back(ref_run(d, 4));
    count = CNT_W'(2);
    start = 1'b1;
    up.in_valid = 1'b1;
    up.in_data  = held[0];
    idx = 0;
    dones = 0;
    after = 0;
    for (int c = 0; c < 40 && dones < 2; c++) begin
      @(negedge clock);
      if (up.in_ready && up.in_valid) idx++;
      if (done) begin
        dones++;
        after = 0;
      end else if (dones == 1) begin
        after++;
        if (dp_clear) check("held_idle_gap", after, 2);
      end
      tick();
      if (dones == 2) start = 1'b0;
      if (idx >= 4) up.in_valid = 1'b0;
      else up.in_data = held[idx];
    end
    start = 1'b0;
    up.in_valid = 1'b0;
    check("held_run_count", dones, 2);
    check("held_beats", idx, 4);
    wait_idle();

    // Randomized runs with random data and stall gaps.
    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(0, 10);
      d = {};
      gaps = {};
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 7))
          0:       d.push_back(S_MIN);
          1:       d.push_back(S_MAX);
          default: d.push_back(sample_t'($urandom));
        endcase
        gaps.push_back(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
      run_normal(d, gaps);
    end

    repeat (5) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
